regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised GPR file for the multicycle core: N_RD combinational read ports, one write-back port.
//  Adds a per-register busy scoreboard: decode marks a destination busy on issue, write-back clears it.
//  Operand-ready flags let the control FSM stall on RAW/WAW hazards.
//  Sits between decode (issue side), the datapath read muxes and the write-back stage.
// PARAMETERS
//  WORD_LEN   16  data width in bits
//  REG_COUNT  8   number of architectural registers; power of two, >=2
//  N_RD       2   number of read ports, 1..4
//  ZERO_REG   1   1: register 0 reads 0, ignores writes, never goes busy; 0: r0 is ordinary
//  ADDR_W     $clog2(REG_COUNT)  derived; do not override
// PORTS
//  clk          in   1              rising-edge clock
//  rst_n        in   1              asynchronous active-low reset
//  rd_addr      in   N_RD*ADDR_W    packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
//  rd_data      out  N_RD*WORD_LEN  packed read data, combinational
//  rd_ready     out  N_RD           1 = register addressed by port k is not busy
//  issue_valid  in   1              decode requests to reserve issue_dst
//  issue_dst    in   ADDR_W         destination register to reserve
//  issue_ready  out  1              1 = reservation accepted this cycle
//  wb_valid     in   1              write-back strobe
//  wb_addr      in   ADDR_W         write-back register
//  wb_data      in   WORD_LEN       write-back data
//  busy_vec     out  REG_COUNT      current busy bits, registered
//  err_wb_idle  out  1              sticky: write-back seen to a non-busy register
// BEHAVIOUR
//  Reset (async, rst_n=0): all registers 0, busy_vec=0, err_wb_idle=0; outputs follow immediately.
//  Reset mid-operation discards all reservations; in-flight write-backs after release write normally and set err_wb_idle.
//  Read: rd_data[k]=regs[rd_addr[k]], zero latency. rd_ready[k]=~busy[rd_addr[k]].
//  Write: wb_valid -> regs[wb_addr]<=wb_data and busy[wb_addr]<=0 at next edge.
//    Visible on reads the following cycle (1-cycle latency without bypass).
//  Issue handshake: issue_ready = ~busy[issue_dst] (combinational, no dependence on issue_valid).
//    issue_valid & issue_ready -> busy[issue_dst]<=1 at next edge.
//    issue_valid & ~issue_ready -> no state change; decode holds and retries (WAW stall).
//  Simultaneous issue and wb, different regs: both take effect.
//  Simultaneous issue and wb, same reg:
//    - reg busy: issue_ready=0, so only the wb applies and the reg ends not busy.
//    - reg idle: issue wins; reg ends busy, data written, err_wb_idle set.
//  wb to a non-busy register: data still written; err_wb_idle<=1, held until reset.
//  ZERO_REG=1 and address 0:
//    - rd_data=0, rd_ready=1, issue_ready=1.
//    - issue sets no busy bit; wb writes are dropped and never raise err_wb_idle.
//  All address fields are full-range (power-of-two depth), so no out-of-range case exists.
// CONFIGURATION
//  REGFILE_WB_BYPASS_EN defined:
//    - read port k with wb_valid & wb_addr==rd_addr[k] (and not zero reg) returns wb_data and rd_ready[k]=1 same cycle.
//    - issue_ready for issue_dst==wb_addr with wb_valid is 1 (reservation may chain onto the retiring write).
//    - Same-cycle issue and wb to the same reg leave it busy.
//  Not defined:
//    - reads return stored value only; rd_ready follows busy_vec; 1-cycle write-to-read latency.
// STRUCTURE
//  Package regfile_pkg: WORD_LEN/REG_COUNT defaults, ADDR_W function, reg_addr_t, reg_word_t typedefs.
//  Sub-module regfile_busy_table: busy bits, issue/wb set-clear logic, err_wb_idle, issue_ready.
//    Top holds storage, read muxes and bypass.
// TESTING
//  Reset: write r3=16'hBEEF, pulse rst_n low mid-cycle -> r3 reads 0, busy_vec=0, err_wb_idle=0 without a clock edge.
//  RAW: issue r5; next cycle rd_addr[0]=5 -> rd_ready[0]=0; wb r5=16'h1234 -> next cycle rd_data=16'h1234, rd_ready=1.
//  WAW: issue r2, reissue r2 before wb -> issue_ready=0, busy_vec[2] stays 1; after wb, issue_ready=1.
//  Zero reg: wb r0=16'hFFFF, issue r0 -> rd_data 0, busy_vec[0]=0, err_wb_idle=0.
//  Stray wb: wb r6=16'h00AA with r6 idle -> r6=16'h00AA, err_wb_idle=1 and stays 1.
//  Bypass (macro on): issue r4, then wb r4=16'h5A5A with rd_addr[1]=4 same cycle -> rd_data 16'h5A5A, rd_ready[1]=1.
//    Macro off: stored value returned and rd_ready[1]=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and word/address types for the GPR file and its busy scoreboard.
package regfile_pkg;

  localparam int WORD_LEN_DEF  = 16;
  localparam int REG_COUNT_DEF = 8;

  // Minimum one address bit so a degenerate depth still yields a legal port width.
  function automatic int addr_w(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  typedef logic [addr_w(REG_COUNT_DEF)-1:0] reg_addr_t;
  typedef logic [WORD_LEN_DEF-1:0]          reg_word_t;

endpackage

// File: rtl/regfile_busy_table.sv
// Per-register busy bits: issue sets, write-back clears, sticky flag for write-backs to idle registers.
// issue_ready is combinational from busy state; REGFILE_WB_BYPASS_EN lets an issue chain onto a same-cycle write-back.
module regfile_busy_table
  import regfile_pkg::*;
#(
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int ZERO_REG  = 1,
  parameter int ADDR_W    = addr_w(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_dst,
  input  logic                 wb_valid,
  input  logic [ADDR_W-1:0]    wb_addr,
  output logic                 issue_ready,
  output logic [REG_COUNT-1:0] busy_vec,
  output logic                 err_wb_idle
);

  logic                 issue_zero;
  logic                 wb_zero;
  logic                 wb_hit_issue;
  logic [REG_COUNT-1:0] busy_nxt;

  assign issue_zero = (ZERO_REG != 0) && (issue_dst == '0);
  assign wb_zero    = (ZERO_REG != 0) && (wb_addr == '0);

`ifdef REGFILE_WB_BYPASS_EN
  assign wb_hit_issue = wb_valid && !wb_zero && (wb_addr == issue_dst);
`else
  assign wb_hit_issue = 1'b0;
`endif

  assign issue_ready = issue_zero | wb_hit_issue | ~busy_vec[issue_dst];

  // Set is applied after clear so a same-cycle issue to an idle register wins.
  always_comb begin
    busy_nxt = busy_vec;
    if (wb_valid && !wb_zero) begin
      busy_nxt[wb_addr] = 1'b0;
    end
    if (issue_valid && issue_ready && !issue_zero) begin
      busy_nxt[issue_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec    <= '0;
      err_wb_idle <= 1'b0;
    end else begin
      busy_vec <= busy_nxt;
      if (wb_valid && !wb_zero && !busy_vec[wb_addr]) begin
        err_wb_idle <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// GPR file with N_RD combinational read ports, one write-back port and a busy scoreboard (REGFILE_WB_BYPASS_EN: wb-to-read bypass).
// Reads are zero-latency, writes visible next cycle; decode stalls on issue_ready=0 until the destination retires.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WORD_LEN  = WORD_LEN_DEF,
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int N_RD      = 2,
  parameter int ZERO_REG  = 1,
  parameter int ADDR_W    = addr_w(REG_COUNT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_RD*ADDR_W-1:0]     rd_addr,
  output logic [N_RD*WORD_LEN-1:0]   rd_data,
  output logic [N_RD-1:0]            rd_ready,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_dst,
  output logic                       issue_ready,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [WORD_LEN-1:0]        wb_data,
  output logic [REG_COUNT-1:0]       busy_vec,
  output logic                       err_wb_idle
);

  logic [WORD_LEN-1:0] regs [REG_COUNT];
  logic                wb_zero;

  assign wb_zero = (ZERO_REG != 0) && (wb_addr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid && !wb_zero) begin
      regs[wb_addr] <= wb_data;
    end
  end

  regfile_busy_table #(
    .REG_COUNT (REG_COUNT),
    .ZERO_REG  (ZERO_REG),
    .ADDR_W    (ADDR_W)
  ) u_busy (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .issue_ready (issue_ready),
    .busy_vec    (busy_vec),
    .err_wb_idle (err_wb_idle)
  );

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              byp;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);

`ifdef REGFILE_WB_BYPASS_EN
    assign byp = wb_valid && !is_zero && (wb_addr == addr);
`else
    assign byp = 1'b0;
`endif

    // Zero register masks storage; bypass forwards the retiring value ahead of the array update.
    assign rd_data[k*WORD_LEN +: WORD_LEN] = is_zero ? '0 : (byp ? wb_data : regs[addr]);
    assign rd_ready[k] = is_zero | byp | ~busy_vec[addr];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard; expected values queued at drive time and popped at observation.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int NRD = 2;
  localparam int AW  = addr_w(REG_COUNT_DEF);
  localparam int WL  = WORD_LEN_DEF;
  localparam int RC  = REG_COUNT_DEF;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*WL-1:0] rd_data;
  logic [NRD-1:0]    rd_ready;
  logic              issue_valid;
  reg_addr_t         issue_dst;
  logic              issue_ready;
  logic              wb_valid;
  reg_addr_t         wb_addr;
  reg_word_t         wb_data;
  logic [RC-1:0]     busy_vec;
  logic              err_wb_idle;

  regfile_scoreboard #(
    .WORD_LEN  (WL),
    .REG_COUNT (RC),
    .N_RD      (NRD),
    .ZERO_REG  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .busy_vec    (busy_vec),
    .err_wb_idle (err_wb_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty observed=%h expected=queued_entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  function automatic logic [15:0] rd0();
    return rd_data[WL-1:0];
  endfunction

  function automatic logic [15:0] rd1();
    return rd_data[2*WL-1:WL];
  endfunction

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rd_addr = '0; issue_valid = 1'b0; issue_dst = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    #2;
    push("reset_busy", 0); push("reset_err", 0); push("reset_rd0", 0);
    pop_chk(busy_vec); pop_chk(err_wb_idle); pop_chk(rd0());
    #10 rst_n = 1'b1;

    // write r3 then async reset mid-cycle
    tick();
    wb_valid = 1'b1; wb_addr = 3; wb_data = 16'hBEEF;
    push("wr_r3", 16'hBEEF);
    tick();
    wb_valid = 1'b0; set_rd(3, 0);
    pop_chk(rd0());
    async_reset_pulse();
    push("rst_r3", 0); push("rst_busy", 0); push("rst_err", 0);
    pop_chk(rd0()); pop_chk(busy_vec); pop_chk(err_wb_idle);
    rst_n = 1'b1;

    // RAW on r5
    tick();
    issue_valid = 1'b1; issue_dst = 5; #1;
    push("raw_issue_ready", 1); pop_chk(issue_ready);
    tick();
    issue_valid = 1'b0; set_rd(5, 0);
    push("raw_rd_ready_busy", 0); push("raw_busy_vec", 8'h20);
    pop_chk(rd_ready[0]); pop_chk(busy_vec);
    wb_valid = 1'b1; wb_addr = 5; wb_data = 16'h1234;
    push("raw_rd_data", 16'h1234); push("raw_rd_ready", 1); push("raw_err", 0);
    tick();
    wb_valid = 1'b0; #1;
    pop_chk(rd0()); pop_chk(rd_ready[0]); pop_chk(err_wb_idle);

    // WAW on r2
    issue_valid = 1'b1; issue_dst = 2;
    tick();
    #1;
    push("waw_reissue_ready", 0); pop_chk(issue_ready);
    tick();
    push("waw_busy_held", 8'h04); pop_chk(busy_vec);
    issue_valid = 1'b0; wb_valid = 1'b1; wb_addr = 2; wb_data = 16'h0002;
    tick();
    wb_valid = 1'b0; set_rd(2, 0);
    push("waw_ready_after_wb", 1); push("waw_r2", 16'h0002); push("waw_busy_clear", 0);
    pop_chk(issue_ready); pop_chk(rd0()); pop_chk(busy_vec);

    // same-cycle issue and wb to a busy register
    issue_valid = 1'b1; issue_dst = 2;
    tick();
    wb_valid = 1'b1; wb_addr = 2; wb_data = 16'h0022; #1;
    push("same_busy_issue_ready", BYP ? 1 : 0); pop_chk(issue_ready);
    tick();
    issue_valid = 1'b0; wb_valid = 1'b0; #1;
    push("same_busy_busy_vec", BYP ? 8'h04 : 8'h00); push("same_busy_r2", 16'h0022);
    push("same_busy_err", 0);
    pop_chk(busy_vec); pop_chk(rd0()); pop_chk(err_wb_idle);
`ifdef REGFILE_WB_BYPASS_EN
    wb_valid = 1'b1; wb_addr = 2; wb_data = 16'h0023;
    tick();
    wb_valid = 1'b0;
`endif

    // zero register
    wb_valid = 1'b1; wb_addr = 0; wb_data = 16'hFFFF;
    issue_valid = 1'b1; issue_dst = 0; set_rd(0, 0);
    push("zero_issue_ready", 1); pop_chk(issue_ready);
    tick();
    wb_valid = 1'b0; issue_valid = 1'b0; #1;
    push("zero_rd", 0); push("zero_rd_ready", 1); push("zero_busy", 0); push("zero_err", 0);
    pop_chk(rd0()); pop_chk(rd_ready[0]); pop_chk(busy_vec); pop_chk(err_wb_idle);

    // stray write-back
    wb_valid = 1'b1; wb_addr = 6; wb_data = 16'h00AA;
    tick();
    wb_valid = 1'b0; set_rd(0, 6);
    push("stray_r6", 16'h00AA); push("stray_err", 1);
    pop_chk(rd1()); pop_chk(err_wb_idle);
    tick(); tick(); tick();
    push("stray_err_sticky", 1); pop_chk(err_wb_idle);

    // issue and wb to different registers, then reset discards the reservation
    issue_valid = 1'b1; issue_dst = 1; wb_valid = 1'b1; wb_addr = 7; wb_data = 16'h0077;
    tick();
    issue_valid = 1'b0; wb_valid = 1'b0; set_rd(7, 1);
    push("diff_busy", 8'h02); push("diff_r7", 16'h0077);
    pop_chk(busy_vec); pop_chk(rd0());
    async_reset_pulse();
    push("midrst_busy", 0); push("midrst_err", 0); push("midrst_r7", 0);
    pop_chk(busy_vec); pop_chk(err_wb_idle); pop_chk(rd0());
    rst_n = 1'b1;
    tick();
    wb_valid = 1'b1; wb_addr = 1; wb_data = 16'h0011;
    tick();
    wb_valid = 1'b0; #1;
    push("inflight_r1", 16'h0011); push("inflight_err", 1);
    pop_chk(rd1()); pop_chk(err_wb_idle);
    async_reset_pulse();
    rst_n = 1'b1;

    // same-cycle issue and wb to an idle register
    tick();
    issue_valid = 1'b1; issue_dst = 3; wb_valid = 1'b1; wb_addr = 3; wb_data = 16'h0033;
    set_rd(3, 0);
    push("idle_same_ready", 1); pop_chk(issue_ready);
    tick();
    issue_valid = 1'b0; wb_valid = 1'b0; #1;
    push("idle_same_busy", 8'h08); push("idle_same_err", 1); push("idle_same_r3", 16'h0033);
    pop_chk(busy_vec); pop_chk(err_wb_idle); pop_chk(rd0());
    wb_valid = 1'b1; wb_addr = 3; wb_data = 16'h0034;
    tick();
    wb_valid = 1'b0; #1;
    push("idle_same_clear", 0); pop_chk(busy_vec);

    // wb-to-read forwarding on port 1
    issue_valid = 1'b1; issue_dst = 4;
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 4; wb_data = 16'h5A5A; set_rd(0, 4);
    push("byp_rd1", BYP ? 16'h5A5A : 16'h0000); push("byp_rd_ready1", BYP ? 1 : 0);
    pop_chk(rd1()); pop_chk(rd_ready[1]);
    tick();
    wb_valid = 1'b0; #1;
    push("post_byp_rd1", 16'h5A5A); push("post_byp_ready1", 1); push("post_byp_busy", 0);
    pop_chk(rd1()); pop_chk(rd_ready[1]); pop_chk(busy_vec);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
